cache_level_2: RTL and testbench
================================

CACHE_LEVEL_2 -- requirements
Module: cache_level_2

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from request acceptance to completion; legal range 1..15.
REQ-002 SHALL have parameter ADDR_BITS, default 10: word-address bits used to index backing storage of 2**ADDR_BITS 32-bit words.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port read_index, input, 1: block read request from the level-1 cache.
REQ-006 SHALL have port write_index, input, 1: single-word write request from the level-1 cache.
REQ-007 SHALL have port addr, input, 32: word address; addr[1:0] is the word offset inside a 4-word block.
REQ-008 SHALL have port write_data, input, 32: word to store on a write request.
REQ-009 SHALL have port stall, output, 1: high while a request is pending; requester must hold its request inputs stable while high.
REQ-010 SHALL have port block_of_data, output, 128: returned block; word k of the block occupies bits [32k+31:32k].
REQ-011 SHALL have port ack, output, 1: one-cycle pulse marking completion of a request.

Function
REQ-012 SHALL implement states IDLE, BUSY, RESP.
REQ-013 In IDLE, a request (read_index or write_index high) that is not a held request (REQ-022) SHALL be accepted: latch type, addr and write_data, load counter with LATENCY-1, go to BUSY.
REQ-014 stall SHALL be combinationally high in the IDLE cycle in which a request is accepted, so the requester stalls with zero delay.
REQ-015 stall SHALL be high throughout BUSY and low in IDLE (except per REQ-014) and in RESP.
REQ-016 In BUSY the counter SHALL decrement once per cycle; on the cycle it equals 0, the state SHALL go to RESP.
REQ-017 On entering RESP after a read, block_of_data SHALL be registered as words mem[{A[ADDR_BITS-1:2],2'bk}] for k=0..3, A = latched addr.
REQ-018 On entering RESP after a write, mem[A[ADDR_BITS-1:0]] SHALL be written with the latched write_data; block_of_data SHALL be left unchanged.
REQ-019 ack SHALL be high for exactly the RESP cycle; RESP SHALL last one cycle and return to IDLE.
REQ-020 Total latency: acceptance in cycle N, ack and stall low in cycle N+LATENCY+1; block_of_data valid from cycle N+LATENCY+1 until the next read completes.
REQ-021 If read_index and write_index are both high at acceptance, the request SHALL be treated as a read; the write SHALL be ignored.
REQ-022 After RESP, a hold flag SHALL record the served type and addr; in IDLE a request with identical type and addr while the flag is set SHALL NOT be re-accepted (stall stays low).
REQ-023 The hold flag SHALL clear in any IDLE cycle where both request inputs are low, or the type or addr differ from the held values; such a differing request is accepted in that same cycle.
REQ-024 Address bits above ADDR_BITS-1 SHALL be ignored (address wrap-around modulo storage size).
REQ-025 Request input changes during BUSY SHALL be ignored; only latched values are used.

Reset
REQ-026 On rst high, state SHALL be IDLE, stall 0, ack 0, block_of_data 0, counter 0, hold flag cleared, latched registers 0, regardless of state, including mid-BUSY.
REQ-027 Backing storage SHALL NOT be reset; a write aborted by reset SHALL leave storage unmodified.
REQ-028 After rst deasserts, a request present in the first clock edge SHALL be accepted normally.

Verification
REQ-029 Write addr=0x10, data=0xDEADBEEF, LATENCY=4: stall high cycles N..N+4, ack at N+5, hold inputs until ack -> storage word 0x10 = 0xDEADBEEF.
REQ-030 After writing 0x11..0x13 = 1,2,3 and 0x10 as above, read addr=0x12 -> at ack block_of_data = 0x00000003_00000002_00000001_DEADBEEF.
REQ-031 Read held asserted at same addr for 10 cycles after ack -> no second acceptance, stall stays low, block_of_data stable; change addr to 0x20 -> accepted same cycle, stall high.
REQ-032 read_index and write_index both high, addr=0x10, write_data=0 -> read performed, word 0x10 still 0xDEADBEEF.
REQ-033 rst pulsed mid-BUSY of write addr=0x30, data=0x55 -> stall 0, ack 0, block_of_data 0 immediately; subsequent read of 0x30 returns prior contents, not 0x55.
REQ-034 Read addr=0x00000410 with ADDR_BITS=10 -> same block as addr 0x10.

Source files
------------

// File: rtl/cache_level_2.sv
// cache_level_2: level-2 backing store serving block reads and single-word
// writes from a level-1 cache with a fixed, parameterised completion latency.
// Requests are latched in IDLE, counted down in BUSY and completed in RESP,
// where ack pulses for one cycle. A hold flag prevents a requester that keeps
// its request asserted after completion from being served a second time.
module cache_level_2 #(
  parameter int LATENCY   = 4,
  parameter int ADDR_BITS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         read_index,
  input  logic         write_index,
  input  logic [31:0]  addr,
  input  logic [31:0]  write_data,
  output logic         stall,
  output logic [127:0] block_of_data,
  output logic         ack
);

  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_BITS;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Backing storage; deliberately never reset.
  logic [DATA_W-1:0] mem [DEPTH];

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_read_q, is_read_d;
  logic [31:0]        addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               ack_q, ack_d;
  logic [127:0]       block_q, block_d;
  logic               hold_q, hold_d;
  logic               hold_read_q, hold_read_d;
  logic [31:0]        hold_addr_q, hold_addr_d;

  logic                 req;
  logic                 req_is_read;
  logic                 held;
  logic                 accept;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] widx;

  // Request decode: read wins when both request lines are high.
  always_comb begin
    req         = read_index | write_index;
    req_is_read = read_index;
    held        = hold_q && req && (req_is_read == hold_read_q) && (addr == hold_addr_q);
    accept      = (state_q == IDLE) && req && !held;
    widx        = addr_q[ADDR_BITS-1:0];
  end

  // Stall is raised combinationally in the accepting IDLE cycle so the
  // requester freezes with no extra delay, and held through BUSY.
  always_comb begin
    stall = (state_q == BUSY) || (accept && !rst);
  end

  // Next-state and datapath computation for the controller.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_read_d   = is_read_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ack_d       = 1'b0;
    block_d     = block_q;
    hold_d      = hold_q;
    hold_read_d = hold_read_q;
    hold_addr_d = hold_addr_q;
    mem_we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Any cycle that is not a repeat of the served request drops the hold.
        if (!held) begin
          hold_d = 1'b0;
        end
        if (accept) begin
          state_d   = BUSY;
          cnt_d     = CNT_W'(LATENCY - 1);
          is_read_d = req_is_read;
          addr_d    = addr;
          wdata_d   = write_data;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          ack_d   = 1'b1;
          if (is_read_q) begin
            for (int k = 0; k < 4; k++) begin
              block_d[32*k +: 32] = mem[{widx[ADDR_BITS-1:2], 2'(k)}];
            end
          end else begin
            mem_we = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d     = IDLE;
        hold_d      = 1'b1;
        hold_read_d = is_read_q;
        hold_addr_d = addr_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state, latched request and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_read_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ack_q       <= 1'b0;
      block_q     <= '0;
      hold_q      <= 1'b0;
      hold_read_q <= 1'b0;
      hold_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_read_q   <= is_read_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ack_q       <= ack_d;
      block_q     <= block_d;
      hold_q      <= hold_d;
      hold_read_q <= hold_read_d;
      hold_addr_q <= hold_addr_d;
    end
  end

  // Storage write on entry to RESP; reset forces IDLE so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[widx] <= wdata_q;
    end
  end

  assign ack           = ack_q;
  assign block_of_data = block_q;

endmodule

// File: tb/tb_cache_level_2.sv
// Directed testbench for cache_level_2 with LATENCY=4, ADDR_BITS=10.
module tb_cache_level_2;

  localparam int LAT = 4;
  localparam int AB  = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         read_index = 1'b0;
  logic         write_index = 1'b0;
  logic [31:0]  addr = '0;
  logic [31:0]  write_data = '0;
  logic         stall;
  logic [127:0] block_of_data;
  logic         ack;

  int checks   = 0;
  int failures = 0;

  cache_level_2 #(.LATENCY(LAT), .ADDR_BITS(AB)) dut (
    .clk          (clk),
    .rst          (rst),
    .read_index   (read_index),
    .write_index  (write_index),
    .addr         (addr),
    .write_data   (write_data),
    .stall        (stall),
    .block_of_data(block_of_data),
    .ack          (ack)
  );

  always #5 clk = ~clk;

  // Drive a request at a negedge and follow it until ack (bounded).
  // ack_cyc = cycles after acceptance at which ack was seen (-1 if never);
  // stall_ok = stall high from acceptance until ack, low with ack.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, output int ack_cyc, output bit stall_ok);
    @(negedge clk);
    read_index  = rd;
    write_index = wr;
    addr        = a;
    write_data  = d;
    #1;
    stall_ok = (stall === 1'b1) && (ack === 1'b0);
    ack_cyc  = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      #1;
      if (ack === 1'b1) begin
        ack_cyc = c;
        if (stall !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (stall !== 1'b1) stall_ok = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    read_index  = 1'b0;
    write_index = 1'b0;
  endtask

  task automatic test_reset();
    int c;
    int seen;
    repeat (2) @(posedge clk);
    @(negedge clk);
    write_index = 1'b1;
    addr        = 32'h11;
    write_data  = 32'h1;
    #1;
    checks++;
    if (stall !== 1'b0 || ack !== 1'b0 || block_of_data !== 128'h0) begin
      failures++;
      $display("FAIL reset_outputs: stall=%b ack=%b block=%h, need 0 0 0", stall, ack, block_of_data);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL first_edge_accept: stall=%b, need 1", stall);
    end
    seen = -1;
    for (c = 1; c <= 40; c++) begin
      @(negedge clk);
      #1;
      if (ack === 1'b1) begin
        seen = c;
        break;
      end
    end
    checks++;
    if (seen != LAT + 1) begin
      failures++;
      $display("FAIL first_edge_latency: ack at %0d, need %0d", seen, LAT + 1);
    end
    idle_inputs();
  endtask

  task automatic test_write();
    int  ac;
    bit  ok;
    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, ac, ok);
    checks++;
    if (ac != LAT + 1 || !ok) begin
      failures++;
      $display("FAIL write_timing: ack at %0d stall_ok=%0b, need %0d 1", ac, ok, LAT + 1);
    end
    idle_inputs();
    issue(1'b0, 1'b1, 32'h12, 32'h2, ac, ok);
    idle_inputs();
    issue(1'b0, 1'b1, 32'h13, 32'h3, ac, ok);
    idle_inputs();
  endtask

  task automatic test_read_block();
    int ac;
    bit ok;
    issue(1'b1, 1'b0, 32'h12, 32'h0, ac, ok);
    checks++;
    if (ac != LAT + 1 || !ok) begin
      failures++;
      $display("FAIL read_timing: ack at %0d stall_ok=%0b, need %0d 1", ac, ok, LAT + 1);
    end
    checks++;
    if (block_of_data !== 128'h00000003_00000002_00000001_DEADBEEF) begin
      failures++;
      $display("FAIL read_block: got %h, need %h", block_of_data,
               128'h00000003_00000002_00000001_DEADBEEF);
    end
  endtask

  // Continues straight from test_read_block with the read still asserted.
  task automatic test_hold();
    int bad;
    int ac;
    bit ok;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (stall !== 1'b0 || ack !== 1'b0 ||
          block_of_data !== 128'h00000003_00000002_00000001_DEADBEEF) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_no_reaccept: %0d bad cycles, need 0", bad);
    end
    issue(1'b1, 1'b0, 32'h20, 32'h0, ac, ok);
    checks++;
    if (ac != LAT + 1 || !ok) begin
      failures++;
      $display("FAIL hold_new_addr: ack at %0d stall_ok=%0b, need %0d 1", ac, ok, LAT + 1);
    end
    idle_inputs();
  endtask

  task automatic test_both_high();
    int ac;
    bit ok;
    issue(1'b1, 1'b1, 32'h10, 32'h0, ac, ok);
    checks++;
    if (block_of_data !== 128'h00000003_00000002_00000001_DEADBEEF) begin
      failures++;
      $display("FAIL both_high_read: got %h, need %h", block_of_data,
               128'h00000003_00000002_00000001_DEADBEEF);
    end
    idle_inputs();
    issue(1'b1, 1'b0, 32'h11, 32'h0, ac, ok);
    checks++;
    if (block_of_data[31:0] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL both_high_no_write: word0=%h, need deadbeef", block_of_data[31:0]);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int ac;
    bit ok;
    issue(1'b0, 1'b1, 32'h21, 32'h12345678, ac, ok);
    issue(1'b1, 1'b0, 32'h20, 32'h0, ac, ok);
    checks++;
    if (ac != LAT + 1 || !ok) begin
      failures++;
      $display("FAIL b2b_timing: ack at %0d stall_ok=%0b, need %0d 1", ac, ok, LAT + 1);
    end
    checks++;
    if (block_of_data[63:32] !== 32'h12345678) begin
      failures++;
      $display("FAIL b2b_data: word1=%h, need 12345678", block_of_data[63:32]);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_busy();
    int ac;
    bit ok;
    issue(1'b0, 1'b1, 32'h30, 32'hAAAA5555, ac, ok);
    idle_inputs();
    issue(1'b1, 1'b0, 32'h12, 32'h0, ac, ok);
    idle_inputs();
    @(negedge clk);
    write_index = 1'b1;
    addr        = 32'h30;
    write_data  = 32'h55;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || ack !== 1'b0 || block_of_data !== 128'h0) begin
      failures++;
      $display("FAIL mid_busy_reset: stall=%b ack=%b block=%h, need 0 0 0", stall, ack, block_of_data);
    end
    write_index = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    issue(1'b1, 1'b0, 32'h30, 32'h0, ac, ok);
    checks++;
    if (ac != LAT + 1 || block_of_data[31:0] !== 32'hAAAA5555) begin
      failures++;
      $display("FAIL aborted_write: ack at %0d word0=%h, need %0d aaaa5555",
               ac, block_of_data[31:0], LAT + 1);
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    int ac;
    bit ok;
    issue(1'b1, 1'b0, 32'h00000410, 32'h0, ac, ok);
    checks++;
    if (block_of_data !== 128'h00000003_00000002_00000001_DEADBEEF) begin
      failures++;
      $display("FAIL addr_wrap: got %h, need %h", block_of_data,
               128'h00000003_00000002_00000001_DEADBEEF);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_block();
    test_hold();
    test_both_high();
    test_back_to_back();
    test_reset_mid_busy();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
